// File: rtl/weight_fetch_sequencer.sv
// weight_fetch_sequencer
// Walks a contiguous range of the weight RAM, issuing one read address per
// cycle, and buffers the returned weights in a small FIFO that feeds the MAC
// datapath as a valid/ready stream. Requests are only issued when the FIFO
// has room for every weight already in flight, so no weight is ever dropped.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   start               command pulse (sampled in IDLE only)
//   base_addr           first RAM address
//   num_weights         weights to fetch, 0..2^ADDR_WIDTH
//   busy, done          status: busy spans the op, done pulses at the end
//   address(_valid)     registered RAM read request
//   read_data(_valid)   RAM response, one cycle after the request
//   weight_out/_valid   FIFO head / non-empty
//   weight_ready        downstream accept
//   overflow_err        sticky: a response arrived with the FIFO full
module weight_fetch_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_weights,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  address_valid,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  read_data_valid,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic                  weight_valid,
  input  logic                  weight_ready,
  output logic                  overflow_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_FINISH} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   num_q, num_d;
  logic [ADDR_WIDTH:0]   issued_q, issued_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic                  addr_valid_q, addr_valid_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  full, push, pop, credit_ok;

  // Output FIFO
  always_comb begin
    full     = (cnt_q == CW'(FIFO_DEPTH));
    push     = read_data_valid && !full;
    pop      = (cnt_q != '0) && weight_ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q | (read_data_valid & full);
    if (push) begin
      mem_d[wr_ptr_q] = read_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  // A request issued now lands in the FIFO two cycles later; by then the
  // next-cycle occupancy plus the request still in flight plus this one
  // must fit, i.e. cnt_d + addr_valid_q + 1 <= FIFO_DEPTH.
  always_comb begin
    credit_ok = ({1'b0, cnt_d} + {{CW{1'b0}}, addr_valid_q}) < (CW+1)'(FIFO_DEPTH);
  end

  // Sequencer FSM and request generation
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    num_d        = num_q;
    issued_d     = issued_q;
    address_d    = address_q;
    addr_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          num_d    = num_weights;
          issued_d = '0;
          if (num_weights != '0) begin
            state_d = S_FETCH;
            // First request goes out the cycle after start
            if (credit_ok) begin
              addr_valid_d = 1'b1;
              address_d    = base_addr;
              issued_d     = (ADDR_WIDTH+1)'(1);
            end
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_FETCH: begin
        if (issued_q < num_q && credit_ok) begin
          addr_valid_d = 1'b1;
          address_d    = base_q + issued_q[ADDR_WIDTH-1:0];
          issued_d     = issued_q + (ADDR_WIDTH+1)'(1);
        end
        if (issued_d == num_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Nothing in flight and the last weight leaves the FIFO this cycle
        if (cnt_d == '0 && !addr_valid_q) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      num_q        <= '0;
      issued_q     <= '0;
      address_q    <= '0;
      addr_valid_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      num_q        <= num_d;
      issued_q     <= issued_d;
      address_q    <= address_d;
      addr_valid_q <= addr_valid_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_FINISH);
  assign address       = address_q;
  assign address_valid = addr_valid_q;
  assign weight_out    = mem_q[rd_ptr_q];
  assign weight_valid  = (cnt_q != '0);
  assign overflow_err  = ovf_q;

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Self-checking bench for weight_fetch_sequencer. A one-cycle RAM model
// returns addr ^ 0x5A. Each command pushes the expected address stream and
// weight stream into queues; a negedge monitor pops and compares whenever
// the DUT issues a request or transfers a weight.
module tb_weight_fetch_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] num_weights;
  logic       busy, done;
  logic [7:0] address;
  logic       address_valid;
  logic [7:0] read_data;
  logic       read_data_valid;
  logic [7:0] weight_out;
  logic       weight_valid;
  logic       weight_ready;
  logic       overflow_err;

  weight_fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_weights(num_weights), .busy(busy), .done(done), .address(address),
    .address_valid(address_valid), .read_data(read_data),
    .read_data_valid(read_data_valid), .weight_out(weight_out),
    .weight_valid(weight_valid), .weight_ready(weight_ready),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // RAM model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_valid <= 1'b0;
      read_data       <= 8'h00;
    end else begin
      read_data_valid <= address_valid;
      read_data       <= address ^ 8'h5A;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_w[$];
  int av_cnt, first_av, last_av, done_cnt, done_cyc, busy_cnt;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (address_valid) begin
        av_cnt++;
        if (first_av < 0) first_av = cyc;
        last_av = cyc;
        if (exp_a.size() == 0) check("unexpected_addr", int'(address), -1);
        else check("address", int'(address), int'(exp_a.pop_front()));
      end
      if (weight_valid && weight_ready) begin
        if (exp_w.size() == 0) check("unexpected_weight", int'(weight_out), -1);
        else check("weight", int'(weight_out), int'(exp_w.pop_front()));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
    end
  end

  task automatic clear_stats();
    av_cnt = 0; first_av = -1; last_av = -1;
    done_cnt = 0; done_cyc = -1; busy_cnt = 0;
  endtask

  task automatic push_expected(input logic [7:0] b, input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = b + 8'(i);
      exp_a.push_back(a);
      exp_w.push_back(a ^ 8'h5A);
    end
  endtask

  // mode 0: ready high; 1: random ready; 2: ready low 20 cycles then high;
  // 3: ready high plus an ignored start pulse while busy
  task automatic run_op(input logic [7:0] b, input int n, input int mode, input bit tm);
    int t0, k;
    clear_stats();
    push_expected(b, n);
    base_addr    = b;
    num_weights  = 9'(n);
    start        = 1'b1;
    weight_ready = (mode == 2) ? 1'b0 : 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (done_cnt == 0 && k < 5000) begin
      if (mode == 1) weight_ready = 1'($urandom_range(0, 1));
      if (mode == 2 && k == 20) begin
        check("stall_requests", av_cnt, 4);
        check("stall_overflow", int'(overflow_err), 0);
      end
      if (mode == 2) weight_ready = (k >= 20);
      if (mode == 3 && k == 2) begin
        base_addr = 8'h80; num_weights = 9'd7; start = 1'b1;
      end
      if (mode == 3 && k == 3) start = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    check("done_seen", done_cnt, 1);
    check("busy_after_done", int'(busy), 0);
    check("addr_queue_empty", exp_a.size(), 0);
    check("weight_queue_empty", exp_w.size(), 0);
    check("request_count", av_cnt, n);
    check("overflow_err", int'(overflow_err), 0);
    if (tm) begin
      if (n == 0) begin
        check("done_cycle", done_cyc, t0 + 1);
        check("busy_cycles", busy_cnt, 1);
      end else begin
        check("done_cycle", done_cyc, t0 + n + 3);
        check("first_addr_cycle", first_av, t0 + 1);
        check("last_addr_cycle", last_av, t0 + n);
        check("busy_cycles", busy_cnt, n + 3);
      end
    end
    weight_ready = 1'b1;
    @(posedge clk); #1;
    check("single_done", done_cnt, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_address"}, int'(address), 0);
    check({tag, "_address_valid"}, int'(address_valid), 0);
    check({tag, "_weight_out"}, int'(weight_out), 0);
    check({tag, "_weight_valid"}, int'(weight_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_overflow_err"}, int'(overflow_err), 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_weights = '0;
    weight_ready = 1'b1;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'h10, 8, 0, 1'b1);
    run_op(8'hFE, 4, 0, 1'b1);
    run_op(8'h30, 16, 2, 1'b0);
    run_op(8'h00, 256, 1, 1'b0);
    run_op(8'h55, 0, 0, 1'b1);
    run_op(8'h20, 5, 3, 1'b1);
    run_op(8'hA0, 37, 1, 1'b0);

    // Reset mid-FETCH after three requests
    clear_stats();
    push_expected(8'h10, 8);
    base_addr = 8'h10; num_weights = 9'd8; start = 1'b1; weight_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (av_cnt < 3 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("midreset_issued", av_cnt, 3);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    exp_a.delete();
    exp_w.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h10, 8, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/weight_fetch_sequencer.md
# weight_fetch_sequencer

Weight fetch sequencer: on a start command it walks a contiguous range of the weight RAM, issuing one address per cycle, and collects the returned weights into a small output FIFO. It sits directly upstream of the weight RAM wrapper (drives `address`/`address_valid`, consumes `read_data`/`read_data_valid`) and feeds the MAC datapath through a valid/ready stream. Credit-based issue guarantees no returned weight is ever dropped, whatever the downstream backpressure.

## Interface
- `DATA_WIDTH`, 8: weight width; must match the RAM wrapper.
- `ADDR_WIDTH`, 8: RAM address width (256 entries).
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle command pulse; sampled only in IDLE.
- `base_addr` in ADDR_WIDTH: first address; sampled with `start`.
- `num_weights` in ADDR_WIDTH+1: number of weights, 0..256; sampled with `start`.
- `busy` out 1: high from the cycle after an accepted start until the `done` cycle inclusive.
- `done` out 1: one-cycle pulse when the last weight has been accepted downstream.
- `address` out ADDR_WIDTH: registered RAM address.
- `address_valid` out 1: registered RAM read request.
- `read_data` in DATA_WIDTH: RAM data.
- `read_data_valid` in 1: RAM data valid; exactly 1 cycle after `address_valid`.
- `weight_out` out DATA_WIDTH: FIFO head.
- `weight_valid` out 1: FIFO non-empty.
- `weight_ready` in 1: downstream accept; transfer occurs when valid && ready.
- `overflow_err` out 1: sticky; set if `read_data_valid` arrives with FIFO full; cleared only by reset.

## Operation
- FSM states:
  - IDLE: start && num_weights≠0 → FETCH; start && num_weights==0 → FINISH.
  - FETCH: transition after the last address is issued → DRAIN.
  - DRAIN: FIFO empty, no request outstanding, and last weight accepted → FINISH.
  - FINISH: one cycle; `done`=1 → IDLE.
- Counters:
  - `issued`: counts 0..num_weights.
  - `outstanding`: 0..1; equals the `address_valid` of the previous cycle.
  - `fifo_count`: 0..FIFO_DEPTH.
- Issue rule: in FETCH, assert `address_valid` next cycle iff issued < num_weights and fifo_count + outstanding + (issue this cycle) ≤ FIFO_DEPTH after accounting for the same-cycle pop. Computed on next-state values, so sustained throughput is 1 weight/cycle with `weight_ready` held high.
- Address: base_addr + issued, modulo 2^ADDR_WIDTH. 0xFE with count 4 yields FE, FF, 00, 01.
- `address` holds its last value when `address_valid`=0.
- FIFO: write on `read_data_valid`, pop on valid && ready. Simultaneous push and pop leaves the count unchanged. Push when full is dropped and sets `overflow_err`; credit logic must make this unreachable.
- `start` while not IDLE is ignored. `read_data_valid` in IDLE is written into the FIFO; this is an error case and only needs to be flagged if it overflows.
- Asynchronous reset mid-operation: everything returns to IDLE immediately and FIFO contents are discarded.

## Timing
- Reset values: `address`=0, `address_valid`=0, `weight_out`=0, `weight_valid`=0, `busy`=0, `done`=0, `overflow_err`=0.
- Start accepted at edge T: `busy`=1 from T+1. First `address_valid` at T+1, first `read_data_valid` at T+2, first `weight_valid` at T+3 (registered FIFO output).
- With ready held high, N weights:
  - last `address_valid` at T+N;
  - last weight presented at T+N+2;
  - `done` at T+N+3;
  - `busy` drops at T+N+4.
- num_weights=0: `done` at T+1 and `busy` high for T+1 only. No request is issued.
- With ready held low: exactly FIFO_DEPTH requests are issued, then `address_valid` stays 0 until a pop. Issue resumes the cycle after the pop.

## Test plan
- Bench RAM model returns addr^0x5A. Reset, start base=0x10, N=8, ready=1:
  - addresses 10..17 on consecutive cycles;
  - weights 4A,4B,48,49,4E,4F,4C,4D;
  - `done` at T+11; `busy` timing as specified.
- base=0xFE, N=4: addresses FE,FF,00,01 (wrap); weights A4,A5,5A,5B.
- N=16 with ready=0 for 20 cycles, then 1:
  - exactly 4 requests before the stall;
  - all 16 weights in order; `overflow_err` stays 0.
- Random ready (50%), N=256, base=0: all 256 weights in order, no overflow, single `done` pulse.
- num_weights=0: `done` at T+1, no `address_valid`. A `start` pulse while busy is ignored (count unchanged).
- Assert `rst_n` low mid-FETCH (after 3 issues):
  - all outputs at reset values immediately;
  - a fresh start afterwards behaves exactly as the first scenario.
